// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length.
`timescale 1ns/1ps

module sha256_padder (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_valid,
  input  logic [7:0]   msg_data,
  input  logic         msg_last,
  output logic         msg_ready,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] block,
  output logic         blk_first,
  output logic         blk_last
);

  localparam logic [2:0] S_FILL  = 3'd0;
  localparam logic [2:0] S_PAD   = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_PAD2  = 3'd3;
  localparam logic [2:0] S_SEND2 = 3'd4;

  logic [2:0]   r_state;
  logic [5:0]   r_cnt;
  logic [60:0]  r_len;
  logic [6:0]   r_n;
  logic         r_extra;
  logic [511:0] r_block;
  logic         r_blk_first;
  logic         r_blk_last;
  logic         r_msg_ready;

  logic [63:0]  w_len_bits;
  logic         w_short;
  logic         w_accept;
  logic         w_blk_hs;
  logic [511:0] w_fill_blk;
  logic [511:0] w_pad_blk;
  logic [511:0] w_pad2_blk;

  assign w_len_bits = {r_len, 3'b000};
  assign w_short    = (r_n <= 7'd55);
  assign w_accept   = msg_valid && r_msg_ready && (r_state == S_FILL);
  assign w_blk_hs   = blk_ready && ((r_state == S_SEND) || (r_state == S_SEND2));

  assign msg_ready  = r_msg_ready;
  assign blk_valid  = (r_state == S_SEND) || (r_state == S_SEND2);
  assign block      = r_block;
  assign blk_first  = r_blk_first;
  assign blk_last   = r_blk_last;

  // Per-byte next-value candidates for the fill, first-pad and extra-pad steps.
  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_byte
      localparam logic [6:0] IDX = 7'(gi);
      logic [7:0] w_len_byte;

      if (gi >= 56) begin : g_len
        assign w_len_byte = w_len_bits[63-8*(gi-56) -: 8];
      end else begin : g_nolen
        assign w_len_byte = 8'h00;
      end

      assign w_fill_blk[511-8*gi -: 8] = (r_cnt == 6'(gi)) ? msg_data
                                                         : r_block[511-8*gi -: 8];

      assign w_pad_blk[511-8*gi -: 8] = (IDX < r_n)  ? r_block[511-8*gi -: 8] :
                                        (IDX == r_n) ? 8'h80 :
                                        w_short      ? w_len_byte : 8'h00;

      // A full 64-byte final block defers the 0x80 marker to the extra block.
      assign w_pad2_blk[511-8*gi -: 8] = ((IDX == 7'd0) && (r_n == 7'd64)) ? 8'h80
                                                                         : w_len_byte;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_cnt       <= 6'd0;
      r_len       <= 61'd0;
      r_n         <= 7'd0;
      r_extra     <= 1'b0;
      r_block     <= 512'd0;
      r_blk_first <= 1'b1;
      r_blk_last  <= 1'b0;
      r_msg_ready <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          r_msg_ready <= 1'b1;
          if (w_accept) begin
            r_block <= w_fill_blk;
            r_cnt   <= r_cnt + 6'd1;
            r_len   <= r_len + 61'd1;
            if (msg_last) begin
              r_n         <= {1'b0, r_cnt} + 7'd1;
              r_state     <= S_PAD;
              r_msg_ready <= 1'b0;
            end else if (r_cnt == 6'd63) begin
              r_blk_last  <= 1'b0;
              r_state     <= S_SEND;
              r_msg_ready <= 1'b0;
            end
          end
        end

        S_PAD: begin
          r_block    <= w_pad_blk;
          r_blk_last <= w_short;
          r_extra    <= !w_short;
          r_state    <= S_SEND;
        end

        S_SEND: begin
          if (w_blk_hs) begin
            if (r_extra) begin
              r_blk_first <= 1'b0;
              r_state     <= S_PAD2;
            end else begin
              r_cnt       <= 6'd0;
              if (r_blk_last) begin
                r_len <= 61'd0;
              end
              // Only a message's final block re-arms blk_first.
              r_blk_first <= r_blk_last;
              r_msg_ready <= 1'b1;
              r_state     <= S_FILL;
            end
          end
        end

        S_PAD2: begin
          r_block    <= w_pad2_blk;
          r_blk_last <= 1'b1;
          r_state    <= S_SEND2;
        end

        S_SEND2: begin
          if (w_blk_hs) begin
            r_cnt       <= 6'd0;
            r_len       <= 61'd0;
            r_extra     <= 1'b0;
            r_blk_first <= 1'b1;
            r_msg_ready <= 1'b1;
            r_state     <= S_FILL;
          end
        end

        default: begin
          r_state     <= S_FILL;
          r_msg_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: msg_valid  in  1  input byte valid.
REQ-004 SHALL have ports: msg_data  in  8  message byte, in message order.
REQ-005 SHALL have ports: msg_last  in  1  final byte of message; qualified by msg_valid.
REQ-006 SHALL have ports: msg_ready  out  1  byte accepted when msg_valid and msg_ready are both high.
REQ-007 SHALL have ports: blk_valid  out  1  padded 512-bit block available.
REQ-008 SHALL have ports: blk_ready  in  1  hash stage accepts block when blk_valid and blk_ready are both high.
REQ-009 SHALL have ports: block  out  512  block data; byte i at block[511-8i -: 8], big-endian words.
REQ-010 SHALL have ports: blk_first  out  1  block is the first of its message (hash stage reloads initial H).
REQ-011 SHALL have ports: blk_last  out  1  block is the final block of its message (hash stage publishes digest).

Function
REQ-012 SHALL implement states FILL, PAD, SEND, PAD2, SEND2.
REQ-013 FILL: msg_ready=1; each accepted byte is written at index cnt (6-bit), cnt increments, and the 61-bit byte-length counter len increments.
REQ-014 FILL, accepted byte with cnt=63 and msg_last=0: cnt wraps to 0; next state SEND; blk_last=0.
REQ-015 FILL, accepted byte with msg_last=1: next state PAD; the final byte count n=cnt+1 (range 1..64) is retained.
REQ-016 PAD, n<=55: 0x80 at byte n; zeros at bytes n+1..55; bytes 56..63 = {len,3'b000}; blk_last=1; next state SEND.
REQ-017 PAD, 56<=n<=63: 0x80 at byte n; zeros at bytes n+1..63; blk_last=0; an extra block is flagged; next state SEND.
REQ-018 PAD, n=64: block left unchanged; blk_last=0; an extra block is flagged, with 0x80 placement deferred to PAD2; next state SEND.
REQ-019 SEND: blk_valid=1; msg_ready=0. On handshake: go to PAD2 if an extra block is flagged, else go to FILL (clear cnt; clear len if blk_last).
REQ-020 PAD2: bytes 0..55 zero, except byte 0 = 0x80 when n=64; bytes 56..63 = {len,3'b000}; blk_last=1; next state SEND2.
REQ-021 SEND2: blk_valid=1. On handshake: go to FILL; clear cnt, len and the extra-block flag.
REQ-022 Latency: full non-last block gives blk_valid on the cycle after the 64th byte is accepted. Last byte gives blk_valid two cycles after acceptance. Extra block gives blk_valid two cycles after the first block's handshake.
REQ-023 While blk_valid=1 and blk_ready=0, block, blk_first and blk_last SHALL hold stable.
REQ-024 blk_first SHALL be 1 for the first block emitted after a message starts, and 0 for all later blocks of that message.
REQ-025 Bit length SHALL be computed modulo 2^64; len wraps silently.
REQ-026 msg_ready=0 in PAD, SEND, PAD2 and SEND2; msg_valid in those states is ignored and not consumed.
REQ-027 Zero-length messages are not supported: msg_last always accompanies a data byte.
REQ-028 Back-to-back messages SHALL be accepted with no idle cycle beyond the states above.

Reset
REQ-029 While rst=1, the block SHALL go to state FILL, with cnt=0, len=0, extra-block flag=0, block=0, blk_valid=0, blk_first=1, blk_last=0 and msg_ready=0.
REQ-030 After rst deasserts, msg_ready=1 from the first clock edge.
REQ-031 Reset mid-message or mid-SEND SHALL discard all partial state; the next accepted byte starts a new message.

Verification
REQ-032 Input "abc" (0x61,0x62,0x63 with last) -> one block 0x61626380, zeros, final word pair 0x00000000_00000018; blk_first=1, blk_last=1.
REQ-033 55 bytes 0x00 -> one block: byte 55 = 0x80, length field 0x1B8; blk_first=1, blk_last=1.
REQ-034 56 bytes -> block 1: byte 56 = 0x80, blk_last=0. Block 2: all zero except length 0x1C0, blk_first=0, blk_last=1.
REQ-035 64 bytes -> block 1 = raw data, blk_last=0. Block 2: byte 0 = 0x80, length 0x200, blk_last=1.
REQ-036 Hold blk_ready=0 for 10 cycles during SEND -> block stable, msg_ready=0, no byte lost. Then assert rst mid-message of 30 bytes and follow with "abc" -> output equals the REQ-032 block.
